// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: a position register driven by HOLD/RING/SCAN
// modes, with a registered one-hot select vector and wrap/done pulses.
module decoder_seq #(
  parameter  int SEL_W     = 5,
  parameter  bit MASK_ZERO = 1'b0,
  localparam int OUT_W     = 2**SEL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             active,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RING,
    ST_SCAN
  } state_t;

  localparam logic [SEL_W-1:0] POS_MAX = '1;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] pos_q, pos_d;
  logic             active_q, active_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    active_d = active_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;

    if (clr) begin
      active_d = 1'b0;
      state_d  = ST_IDLE;
    end else if (en) begin
      if (load) begin
        pos_d    = sel;
        active_d = 1'b1;
        case (mode)
          2'b01:   state_d = ST_RING;
          2'b10:   state_d = ST_SCAN;
          default: state_d = ST_HOLD;
        endcase
      end else begin
        case (state_q)
          ST_RING: begin
            pos_d = pos_q + SEL_W'(1);
            if (pos_q == POS_MAX) begin
              wrap_d = 1'b1;
            end
          end
          ST_SCAN: begin
            if (pos_q == POS_MAX) begin
              active_d = 1'b0;
              state_d  = ST_IDLE;
              done_d   = 1'b1;
            end else begin
              pos_d = pos_q + SEL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // out is decoded from the next state so it lands in the same cycle as idx
    out_d = '0;
    if (active_d && !(MASK_ZERO && (pos_d == '0))) begin
      out_d[pos_d] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      active_q <= 1'b0;
      out_q    <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      active_q <= active_d;
      out_q    <= out_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign out    = out_q;
  assign idx    = pos_q;
  assign active = active_q;
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: directed vectors push expected responses,
// a negedge monitor pops and compares them against two DUT instances.
module tb_decoder_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic        clr   = 1'b0;
  logic        load  = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic [4:0]  sel   = 5'd0;

  logic [31:0] out_a, out_m;
  logic [4:0]  idx_a, idx_m;
  logic        active_a, active_m;
  logic        wrap_a, wrap_m;
  logic        done_a, done_m;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  idx;
    logic        active;
    logic        wrap;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  decoder_seq #(.SEL_W(5), .MASK_ZERO(1'b0)) dut_a (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .load(load),
    .mode(mode), .sel(sel), .out(out_a), .idx(idx_a),
    .active(active_a), .wrap(wrap_a), .done(done_a)
  );

  decoder_seq #(.SEL_W(5), .MASK_ZERO(1'b1)) dut_m (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .load(load),
    .mode(mode), .sel(sel), .out(out_m), .idx(idx_m),
    .active(active_m), .wrap(wrap_m), .done(done_m)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; the hand-computed response after the edge goes to the scoreboard
  task automatic applyStimulus(input logic i_en, input logic i_clr, input logic i_load,
                               input logic [1:0] i_mode, input logic [4:0] i_sel,
                               input logic [31:0] e_out, input logic [4:0] e_idx,
                               input logic e_act, input logic e_wrap, input logic e_done);
    exp_t e;
    en   = i_en;
    clr  = i_clr;
    load = i_load;
    mode = i_mode;
    sel  = i_sel;
    @(posedge clock);
    e.out    = e_out;
    e.idx    = e_idx;
    e.active = e_act;
    e.wrap   = e_wrap;
    e.done   = e_done;
    sb_q.push_back(e);
    #1;
  endtask

  // The masked instance differs only in that bit 0 is never driven
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("out",      out_a,    e.out);
      checkOutput("idx",      32'(idx_a), 32'(e.idx));
      checkOutput("active",   32'(active_a), 32'(e.active));
      checkOutput("wrap",     32'(wrap_a), 32'(e.wrap));
      checkOutput("done",     32'(done_a), 32'(e.done));
      checkOutput("mz_out",   out_m,    e.out & ~32'h1);
      checkOutput("mz_active", 32'(active_m), 32'(e.active));
      checkOutput("mz_wrap",  32'(wrap_m), 32'(e.wrap));
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out"},    out_a, 32'h0);
    checkOutput({tag, "_idx"},    32'(idx_a), 32'h0);
    checkOutput({tag, "_active"}, 32'(active_a), 32'h0);
    checkOutput({tag, "_wrap"},   32'(wrap_a), 32'h0);
    checkOutput({tag, "_done"},   32'(done_a), 32'h0);
    checkOutput({tag, "_mz_out"}, out_m, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;

    // HOLD at 5, stable over 10 enabled cycles even with mode toggling
    applyStimulus(1, 0, 1, 2'b00, 5'd5, 32'h0000_0020, 5'd5, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 2'(i % 4), 5'd0, 32'h0000_0020, 5'd5, 1, 0, 0);
    end

    // RING from 30 through the wrap
    applyStimulus(1, 0, 1, 2'b01, 5'd30, 32'h4000_0000, 5'd30, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h8000_0000, 5'd31, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0000_0001, 5'd0,  1, 1, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0000_0002, 5'd1,  1, 0, 0);

    // en=0 freezes everything, then RING resumes ignoring a mode change
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 5'd9, 32'h0000_0002, 5'd1, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 2'b00, 5'd0, 32'h0000_0004, 5'd2, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b10, 5'd0, 32'h0000_0008, 5'd3, 1, 0, 0);

    // clr beats load; IDLE then stays put
    applyStimulus(1, 1, 1, 2'b01, 5'd20, 32'h0, 5'd3, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b01, 5'd0,  32'h0, 5'd3, 0, 0, 0);

    // SCAN from 29 to termination
    applyStimulus(1, 0, 1, 2'b10, 5'd29, 32'h2000_0000, 5'd29, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h4000_0000, 5'd30, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h8000_0000, 5'd31, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0,         5'd31, 0, 0, 1);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0,         5'd31, 0, 0, 0);

    // SCAN loaded at the last position
    applyStimulus(1, 0, 1, 2'b10, 5'd31, 32'h8000_0000, 5'd31, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b10, 5'd0,  32'h0,         5'd31, 0, 0, 1);

    // reload in RING at 31 suppresses the wrap
    applyStimulus(1, 0, 1, 2'b01, 5'd31, 32'h8000_0000, 5'd31, 1, 0, 0);
    applyStimulus(1, 0, 1, 2'b10, 5'd2,  32'h0000_0004, 5'd2,  1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0000_0008, 5'd3,  1, 0, 0);

    // reserved mode behaves as HOLD
    applyStimulus(1, 0, 1, 2'b11, 5'd7, 32'h0000_0080, 5'd7, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b11, 5'd0, 32'h0000_0080, 5'd7, 1, 0, 0);

    // index 0 in HOLD: masked instance shows nothing but stays active
    applyStimulus(1, 0, 1, 2'b00, 5'd0, 32'h0000_0001, 5'd0, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0, 32'h0000_0001, 5'd0, 1, 0, 0);

    // async reset mid-SCAN, then remain IDLE
    applyStimulus(1, 0, 1, 2'b10, 5'd10, 32'h0000_0400, 5'd10, 1, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 5'd0,  32'h0000_0800, 5'd11, 1, 0, 0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkAllZero("areset");
    checkOutput("areset_mz_active", 32'(active_m), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 2'b10, 5'd0, 32'h0, 5'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b01, 5'd0, 32'h0, 5'd0, 0, 0, 0);

    repeat (2) @(negedge clock);
    #1;
    checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
